i2c_slave_regbank: RTL
======================

I2C_SLAVE_REGBANK -- requirements
Module: i2c_slave_regbank

Interface
REQ-001 Parameter: I2C_ADDRESS, 0, 7-bit slave address matched against address byte bits [7:1].
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse from byte serializer: start or repeated start.
REQ-005 stop  input  1  one-cycle pulse from byte serializer: stop condition.
REQ-006 write_data  input  8  received byte; valid only while wr=1.
REQ-007 wr  input  1  one-cycle byte strobe.
REQ-008 wr_ack  output  1  ACK decision for the most recent byte; 1=ACK, 0=NACK.
REQ-009 reg_out  output  64  eight 8-bit registers; register n at bits [8n+7:8n].
REQ-010 reg_strobe  output  8  one-cycle pulse per register, set on the cycle reg_out[n] changes.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, ADDR, PTR, DATA, DISCARD; 3-bit register; busy = (state != IDLE).
REQ-013 start in any state -> ADDR, next cycle; start takes priority over a simultaneous wr or stop.
REQ-014 ADDR, wr: write_data[7:1]==I2C_ADDRESS and write_data[0]==0 -> PTR, wr_ack<=1; otherwise -> IDLE, wr_ack<=0 (read requests always NACKed).
REQ-015 PTR, wr: write_data[7:3]==0 -> ptr<=write_data[2:0], DATA, wr_ack<=1; otherwise -> DISCARD, wr_ack<=0.
REQ-016 DATA, wr: write register ptr with write_data, ptr<=ptr+1 modulo 8 (7 wraps to 0), wr_ack<=1; stay in DATA.
REQ-017 DISCARD, wr: wr_ack<=0, no register change; IDLE, wr: ignored, wr_ack unchanged.
REQ-018 wr_ack registered: valid the cycle after wr; held until the next wr is decided, start, or reset.
REQ-019 start clears wr_ack to 0.
REQ-020 stop in any state -> IDLE next cycle; stop with simultaneous wr: stop wins, byte dropped.
REQ-021 More than 8 data bytes in one transaction wrap ptr and overwrite earlier registers; the last byte written to a register wins.
REQ-022 reg_strobe is zero on all cycles other than those in REQ-010; a register written with its existing value still strobes.

Reset
REQ-023 reset=1 at a clock edge: state IDLE, ptr 0, wr_ack 0, reg_out 0, reg_strobe 0, shadow 0, dirty 0.
REQ-024 Reset mid-transaction discards all staged bytes; no reg_strobe pulse results.
REQ-025 reset overrides start, stop and wr in the same cycle.

Configuration
REQ-026 Macro I2C_REGBANK_ATOMIC_EN defined: DATA writes go to an 8x8 shadow and set dirty[ptr]; reg_out is unchanged during the transaction.
REQ-027 With I2C_REGBANK_ATOMIC_EN, stop in PTR or DATA copies every dirty shadow into reg_out, pulses reg_strobe[n] for each dirty n on the cycle after stop, and clears dirty.
REQ-028 With I2C_REGBANK_ATOMIC_EN, start (repeated) or stop in any other state clears dirty, with no commit and no strobe.
REQ-029 Macro undefined: DATA writes update reg_out[ptr] directly on the cycle after wr with reg_strobe[ptr] pulsing that cycle; no shadow or dirty storage exists; stop only returns to IDLE.

Verification
REQ-030 I2C_ADDRESS=0x2A; start, 0x54, 0x03, 0xAB, 0xCD, stop -> wr_ack 1,1,1,1; reg3=0xAB, reg4=0xCD; reg_strobe=0x18 (ATOMIC: one pulse, cycle after stop; else separate pulses per byte).
REQ-031 start, 0x56 (wrong address) then 0x01 -> wr_ack 0; state IDLE; second byte ignored; reg_out unchanged.
REQ-032 start, 0x55 (read bit) -> wr_ack 0; start, 0x54, 0x09 (bad pointer), 0x11 -> wr_ack 1,0,0; no register changes.
REQ-033 start, 0x54, 0x06, 0x01, 0x02, 0x03, stop -> reg6=0x01, reg7=0x02, reg0=0x03 (pointer wrap); reg_strobe=0xC1.
REQ-034 ATOMIC: start, 0x54, 0x00, 0x77, start, 0x54, 0x01, 0x88, stop -> reg0 unchanged, reg1=0x88, reg_strobe=0x02.
REQ-035 ATOMIC: start, 0x54, 0x02, 0x5A, reset asserted before stop -> reg_out=0, no reg_strobe pulse, busy=0.

Source files
------------

// File: rtl/i2c_slave_regbank.sv
// I2C slave register bank: address/pointer/data byte decoder driving eight 8-bit registers.
// Define I2C_REGBANK_ATOMIC_EN to stage writes in a shadow bank that is committed on stop.
module i2c_slave_regbank #(
    parameter logic [6:0] I2C_ADDRESS = 7'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  write_data,
    input  logic        wr,
    output logic        wr_ack,
    output logic [63:0] reg_out,
    output logic [7:0]  reg_strobe,
    output logic        busy
);

    localparam int unsigned REG_W  = 8;
    localparam int unsigned N_REGS = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned BANK_W = REG_W * N_REGS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_PTR     = 3'd2,
        S_DATA    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [PTR_W-1:0]    ptr, ptr_next;
    logic                ack_next;
    logic [BANK_W-1:0]   reg_next;
    logic [N_REGS-1:0]   strobe_next;
    logic [5:0]          idx;

`ifdef I2C_REGBANK_ATOMIC_EN
    logic [BANK_W-1:0]   shadow, shadow_next;
    logic [N_REGS-1:0]   dirty, dirty_next;
`endif

    assign idx = {ptr, 3'b000};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            wr_ack     <= 1'b0;
            reg_out    <= '0;
            reg_strobe <= '0;
            busy       <= 1'b0;
`ifdef I2C_REGBANK_ATOMIC_EN
            shadow     <= '0;
            dirty      <= '0;
`endif
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            wr_ack     <= ack_next;
            reg_out    <= reg_next;
            reg_strobe <= strobe_next;
            busy       <= (state_next != S_IDLE);
`ifdef I2C_REGBANK_ATOMIC_EN
            shadow     <= shadow_next;
            dirty      <= dirty_next;
`endif
        end
    end

    // Next state and next register values; start beats stop beats wr
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        ack_next    = wr_ack;
        reg_next    = reg_out;
        strobe_next = '0;
`ifdef I2C_REGBANK_ATOMIC_EN
        shadow_next = shadow;
        dirty_next  = dirty;
`endif
        if (start) begin
            state_next = S_ADDR;
            ack_next   = 1'b0;
`ifdef I2C_REGBANK_ATOMIC_EN
            dirty_next = '0;
`endif
        end else if (stop) begin
            state_next = S_IDLE;
`ifdef I2C_REGBANK_ATOMIC_EN
            if (state == S_PTR || state == S_DATA) begin
                for (int n = 0; n < int'(N_REGS); n++) begin
                    if (dirty[n]) reg_next[n*REG_W +: REG_W] = shadow[n*REG_W +: REG_W];
                end
                strobe_next = dirty;
            end
            dirty_next = '0;
`endif
        end else if (wr) begin
            case (state)
                S_ADDR: begin
                    if (write_data[7:1] == I2C_ADDRESS && !write_data[0]) begin
                        state_next = S_PTR;
                        ack_next   = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        ack_next   = 1'b0;
                    end
                end
                S_PTR: begin
                    if (write_data[7:3] == 5'd0) begin
                        ptr_next   = write_data[2:0];
                        state_next = S_DATA;
                        ack_next   = 1'b1;
                    end else begin
                        state_next = S_DISCARD;
                        ack_next   = 1'b0;
                    end
                end
                S_DATA: begin
`ifdef I2C_REGBANK_ATOMIC_EN
                    shadow_next[idx +: REG_W] = write_data;
                    dirty_next[ptr]           = 1'b1;
`else
                    reg_next[idx +: REG_W] = write_data;
                    strobe_next[ptr]       = 1'b1;
`endif
                    ptr_next = ptr + PTR_W'(1);
                    ack_next = 1'b1;
                end
                S_DISCARD: ack_next = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
